// File: rtl/shift_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter_pkg
// Brief    : Op encodings and result-register state encoding for shift_arbiter
// Revision : 1.0  initial release
// ============================================================================
package shift_arbiter_pkg;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_SRL  = 2'b11;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter_if
// Brief    : Two requester channels plus one response channel
// Revision : 1.0  initial release
// ============================================================================
interface shift_arbiter_if;

    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [4:0]  req0_b;
    logic [1:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [4:0]  req1_b;
    logic [1:0]  req1_op;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface
`default_nettype wire

// File: rtl/shift_arbiter_shifter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter_shifter
// Brief    : Combinational 32-bit barrel shifter, control {ctl1,ctl0}
// Revision : 1.0  initial release
// ============================================================================
module shift_arbiter_shifter
    import shift_arbiter_pkg::*;
(
    input  wire logic [31:0] i_a,
    input  wire logic [4:0]  i_b,
    input  wire logic        i_ctl0,
    input  wire logic        i_ctl1,
    output logic      [31:0] o_y
);

    always_comb begin
        o_y = i_a;
        case ({i_ctl1, i_ctl0})
            OP_SLL:  o_y = i_a << i_b;
            OP_SRA:  o_y = $signed(i_a) >>> i_b;
            OP_SRL:  o_y = i_a >> i_b;
            default: o_y = i_a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter
// Brief    : Round-robin arbiter feeding one shifter into a single result register
// Revision : 1.0  initial release
// ============================================================================
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  wire logic     clk,
    input  wire logic     reset,
    shift_arbiter_if.slave bus
);

    state_t      r_state;
    logic        r_prio;
    logic [31:0] r_data;
    logic        r_id;

    logic        w_can_accept;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_grant;
    logic [31:0] w_a;
    logic [4:0]  w_b;
    logic [1:0]  w_op;
    logic [4:0]  w_sh_b;
    logic        w_ctl0;
    logic        w_ctl1;
    logic [31:0] w_y;

    // Gated by reset so no requester sees ready while the block is held in reset.
    assign w_can_accept = !reset && ((r_state == ST_EMPTY) || bus.rsp_ready);
    assign w_grant0     = w_can_accept && bus.req0_valid && (!bus.req1_valid || !r_prio);
    assign w_grant1     = w_can_accept && bus.req1_valid && (!bus.req0_valid ||  r_prio);
    assign w_grant      = w_grant0 || w_grant1;

    assign w_a  = w_grant1 ? bus.req1_a  : bus.req0_a;
    assign w_b  = w_grant1 ? bus.req1_b  : bus.req0_b;
    assign w_op = w_grant1 ? bus.req1_op : bus.req0_op;

    // Pass is realised as a zero-distance left shift.
    assign w_sh_b = (w_op == OP_PASS) ? 5'd0 : w_b;
    assign w_ctl0 = (w_op == OP_PASS) ? 1'b1 : w_op[0];
    assign w_ctl1 = (w_op == OP_PASS) ? 1'b0 : w_op[1];

    shift_arbiter_shifter u_shifter (
        .i_a    (w_a),
        .i_b    (w_sh_b),
        .i_ctl0 (w_ctl0),
        .i_ctl1 (w_ctl1),
        .o_y    (w_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_prio  <= RR_INIT;
            r_data  <= '0;
            r_id    <= 1'b0;
        end else if (w_grant) begin
            r_state <= ST_FULL;
            r_data  <= w_y;
            r_id    <= w_grant1;
            r_prio  <= ~w_grant1;
        end else if ((r_state == ST_FULL) && bus.rsp_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.rsp_valid  = (r_state == ST_FULL);
    assign bus.rsp_data   = r_data;
    assign bus.rsp_id     = r_id;

endmodule
`default_nettype wire
